// File: rtl/dionysus_sdram_arbiter.sv
// dionysus_sdram_arbiter: shares the SDRAM command bus between the write and
// read engines (round-robin with a hold limit), owns the refresh timer and
// registers the selected engine's command fields onto the pins.
// Optional build macro SDRAM_ARB_STATS_EN adds saturating refresh/preempt
// counters on debug[30:7]; without it those bits read zero.

`ifndef SDRAM_CMD_LOAD_MODE
`define SDRAM_CMD_LOAD_MODE       3'b000
`endif
`ifndef SDRAM_CMD_AR
`define SDRAM_CMD_AR              3'b001
`endif
`ifndef SDRAM_CMD_PRECHARGE
`define SDRAM_CMD_PRECHARGE       3'b010
`endif
`ifndef SDRAM_CMD_ACTIVE
`define SDRAM_CMD_ACTIVE          3'b011
`endif
`ifndef SDRAM_CMD_WRITE
`define SDRAM_CMD_WRITE           3'b100
`endif
`ifndef SDRAM_CMD_READ
`define SDRAM_CMD_READ            3'b101
`endif
`ifndef SDRAM_CMD_BURST_TERMINATE
`define SDRAM_CMD_BURST_TERMINATE 3'b110
`endif
`ifndef SDRAM_CMD_NOP
`define SDRAM_CMD_NOP             3'b111
`endif

module dionysus_sdram_arbiter #(
    parameter int REFRESH_INTERVAL = 1560,
    parameter int T_RFC            = 8,
    parameter int MAX_HOLD         = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_request,
    input  logic        rd_request,
    input  logic        wr_idle,
    input  logic        rd_idle,
    output logic        wr_enable,
    output logic        rd_enable,
    output logic        auto_refresh,
    input  logic [2:0]  wr_command,
    input  logic [11:0] wr_address,
    input  logic [1:0]  wr_bank,
    input  logic [15:0] wr_data,
    input  logic [1:0]  wr_mask,
    input  logic [2:0]  rd_command,
    input  logic [11:0] rd_address,
    input  logic [1:0]  rd_bank,
    input  logic [1:0]  rd_mask,
    output logic [2:0]  sdram_command,
    output logic [11:0] sdram_address,
    output logic [1:0]  sdram_bank,
    output logic [15:0] sdram_data_out,
    output logic [1:0]  sdram_data_mask,
    output logic [31:0] debug
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int WAIT_W = $clog2(T_RFC + 1);
    localparam logic [15:0]       REF_RELOAD = 16'(REFRESH_INTERVAL - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);
    localparam logic [WAIT_W-1:0] RFC_LOAD   = WAIT_W'(T_RFC);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GRANT_WR = 3'd1,
        ST_GRANT_RD = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_REF_CMD  = 3'd4,
        ST_REF_WAIT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_WR   = 2'd1,
        SEL_RD   = 2'd2
    } sel_t;

    state_t            state_q, state_d;
    logic              last_rd_q, last_rd_d;   // 1 = read engine held the bus last
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [15:0]       ref_timer_q;
    logic              ref_pending_q;
    logic              refresh_missed_q;
    logic              auto_refresh_q;
    logic              ref_clear;
    logic              ar_cmd;
    sel_t              sel;

    assign wr_enable    = (state_q == ST_GRANT_WR);
    assign rd_enable    = (state_q == ST_GRANT_RD);
    assign auto_refresh = auto_refresh_q;

    // Refresh timer: periodic request, sticky flag if a request is still unserved when the next one fires
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_timer_q      <= REF_RELOAD;
            ref_pending_q    <= 1'b0;
            refresh_missed_q <= 1'b0;
            auto_refresh_q   <= 1'b0;
        end else begin
            auto_refresh_q <= ref_pending_q;
            if (ref_timer_q == 16'd0) begin
                ref_timer_q   <= REF_RELOAD;
                ref_pending_q <= 1'b1;
                if (ref_pending_q && !ref_clear) begin
                    refresh_missed_q <= 1'b1;
                end
            end else begin
                ref_timer_q <= ref_timer_q - 16'd1;
                if (ref_clear) begin
                    ref_pending_q <= 1'b0;
                end
            end
        end
    end

    // Arbitration state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_rd_q <= 1'b1;
            hold_q    <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            hold_q    <= hold_d;
            wait_q    <= wait_d;
        end
    end

    // Next-state, pin source select and refresh handshake
    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        hold_d    = hold_q;
        wait_d    = wait_q;
        sel       = SEL_NONE;
        ar_cmd    = 1'b0;
        ref_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hold_d = '0;
                if (ref_pending_q) begin
                    state_d = ST_REF_CMD;
                end else if (wr_request && (!rd_request || last_rd_q)) begin
                    state_d = ST_GRANT_WR;
                end else if (rd_request) begin
                    state_d = ST_GRANT_RD;
                end
            end
            ST_GRANT_WR: begin
                sel = SEL_WR;
                if (!wr_request || ref_pending_q || (rd_request && hold_q == HOLD_LAST)) begin
                    state_d   = ST_DRAIN;
                    last_rd_d = 1'b0;
                    hold_d    = '0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_GRANT_RD: begin
                sel = SEL_RD;
                if (!rd_request || ref_pending_q || (wr_request && hold_q == HOLD_LAST)) begin
                    state_d   = ST_DRAIN;
                    last_rd_d = 1'b1;
                    hold_d    = '0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Keep the drained engine on the pins so its closing commands go out
                if (last_rd_q) begin
                    sel = SEL_RD;
                end else begin
                    sel = SEL_WR;
                end
                if (last_rd_q ? rd_idle : wr_idle) begin
                    state_d = ref_pending_q ? ST_REF_CMD : ST_IDLE;
                end
            end
            ST_REF_CMD: begin
                ar_cmd    = 1'b1;
                ref_clear = 1'b1;
                wait_d    = RFC_LOAD;
                state_d   = ST_REF_WAIT;
            end
            ST_REF_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin register: every field taken from one source in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            sdram_command   <= `SDRAM_CMD_NOP;
            sdram_address   <= '0;
            sdram_bank      <= '0;
            sdram_data_out  <= '0;
            sdram_data_mask <= '0;
        end else begin
            case (sel)
                SEL_WR: begin
                    sdram_command   <= wr_command;
                    sdram_address   <= wr_address;
                    sdram_bank      <= wr_bank;
                    sdram_data_out  <= wr_data;
                    sdram_data_mask <= wr_mask;
                end
                SEL_RD: begin
                    sdram_command   <= rd_command;
                    sdram_address   <= rd_address;
                    sdram_bank      <= rd_bank;
                    sdram_data_out  <= '0;
                    sdram_data_mask <= rd_mask;
                end
                default: begin
                    sdram_command   <= ar_cmd ? `SDRAM_CMD_AR : `SDRAM_CMD_NOP;
                    sdram_address   <= '0;
                    sdram_bank      <= '0;
                    sdram_data_out  <= '0;
                    sdram_data_mask <= '0;
                end
            endcase
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    logic [11:0] refresh_count_q;
    logic [11:0] preempt_count_q;
    logic        preempt;

    // A grant is preempted when it ends while its engine still wants the bus
    assign preempt = (state_d == ST_DRAIN) &&
                     (((state_q == ST_GRANT_WR) && wr_request) ||
                      ((state_q == ST_GRANT_RD) && rd_request));

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_count_q <= '0;
            preempt_count_q <= '0;
        end else begin
            if (ar_cmd && refresh_count_q != 12'hFFF) begin
                refresh_count_q <= refresh_count_q + 12'd1;
            end
            if (preempt && preempt_count_q != 12'hFFF) begin
                preempt_count_q <= preempt_count_q + 12'd1;
            end
        end
    end

    assign debug[30:7] = {preempt_count_q, refresh_count_q};
`else
    assign debug[30:7] = '0;
`endif

    assign debug[31]  = 1'b0;
    assign debug[6:0] = {refresh_missed_q, auto_refresh_q, rd_enable, wr_enable, state_q};

endmodule
